// File: rtl/uv_pred_sched.sv
// uv_pred_sched: walks the shared 8x8 U/V predictor through the enabled
// chroma modes (DC, TM, VE, HE) for one macroblock, with a stall watchdog.
// Ports: mb_start/mb_x/mb_y/mb_busy/mb_done - macroblock request side
//        pred_start/pred_mode/pred_x/pred_y/pred_done - predictor handshake
//        out_valid/out_mode/out_ready - result handshake to the cost stage
//        err_timeout - sticky abandoned-mode flag, cleared by the next start
module uv_pred_sched #(
  parameter int BLOCK_NUM = 10,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mb_start,
  input  logic [BLOCK_NUM-1:0] mb_x,
  input  logic [BLOCK_NUM-1:0] mb_y,
  output logic                 mb_busy,
  output logic                 mb_done,
  output logic                 pred_start,
  output logic [1:0]           pred_mode,
  output logic [BLOCK_NUM-1:0] pred_x,
  output logic [BLOCK_NUM-1:0] pred_y,
  input  logic                 pred_done,
  output logic                 out_valid,
  output logic [1:0]           out_mode,
  input  logic                 out_ready,
  output logic                 err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      mask;
  logic [WD_W-1:0] wd;
  logic            wd_exp;
  logic            nxt_ok;
  logic [1:0]      nxt_mode;

  // The count advances on this cycle; hitting TIMEOUT-1 abandons the mode.
  assign wd_exp = (wd >= WD_W'(TIMEOUT - 2));

  // Lowest enabled mode above the current one.
  always_comb begin
    nxt_ok   = 1'b0;
    nxt_mode = pred_mode;
    for (int j = 3; j >= 0; j--) begin
      if (j > int'(pred_mode) && mask[j]) begin
        nxt_ok   = 1'b1;
        nxt_mode = 2'(j);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (mb_start) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (pred_done)   state_nx = S_OUT;
        else if (wd_exp) state_nx = S_NEXT;
      end
      S_OUT:   if (out_ready) state_nx = S_NEXT;
      S_NEXT:  state_nx = nxt_ok ? S_ISSUE : S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mask        <= '0;
      wd          <= '0;
      pred_mode   <= '0;
      pred_x      <= '0;
      pred_y      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (mb_start) begin
            pred_x      <= mb_x;
            pred_y      <= mb_y;
            mask        <= {mb_x != '0, mb_y != '0, 2'b11};
            pred_mode   <= 2'd0;
            err_timeout <= 1'b0;
          end
        end
        S_ISSUE: wd <= '0;
        S_WAIT: begin
          if (wd != {WD_W{1'b1}}) wd <= wd + 1'b1;
          if (!pred_done && wd_exp) err_timeout <= 1'b1;
        end
        S_NEXT: if (nxt_ok) pred_mode <= nxt_mode;
        default: ;
      endcase
    end
  end

  assign mb_busy    = (state != S_IDLE);
  assign mb_done    = (state == S_FIN);
  assign pred_start = (state == S_ISSUE);
  assign out_valid  = (state == S_OUT);
  assign out_mode   = pred_mode;

endmodule

// File: tb/tb_uv_pred_sched.sv
// tb_uv_pred_sched: scoreboard bench for the chroma prediction scheduler.
// Expected issue/output mode sequences are queued at mb_start.
module tb_uv_pred_sched;

  localparam int BN = 10;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mb_start;
  logic [BN-1:0] mb_x;
  logic [BN-1:0] mb_y;
  logic          mb_busy;
  logic          mb_done;
  logic          pred_start;
  logic [1:0]    pred_mode;
  logic [BN-1:0] pred_x;
  logic [BN-1:0] pred_y;
  logic          pred_done;
  logic          out_valid;
  logic [1:0]    out_mode;
  logic          out_ready;
  logic          err_timeout;

  logic pd_model = 1'b0;
  logic pd_inj   = 1'b0;
  logic pd_late  = 1'b0;
  assign pred_done = pd_model | pd_inj | pd_late;

  uv_pred_sched #(.BLOCK_NUM(BN), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mb_start(mb_start),
    .mb_x(mb_x),
    .mb_y(mb_y),
    .mb_busy(mb_busy),
    .mb_done(mb_done),
    .pred_start(pred_start),
    .pred_mode(pred_mode),
    .pred_x(pred_x),
    .pred_y(pred_y),
    .pred_done(pred_done),
    .out_valid(out_valid),
    .out_mode(out_mode),
    .out_ready(out_ready),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  int issue_q[$];
  int out_q[$];

  logic          stall_en  = 1'b0;
  logic          inject_en = 1'b0;
  logic          hang_en   = 1'b0;
  logic [1:0]    hang_mode = 2'd0;
  logic [BN-1:0] cur_x = '0;
  logic [BN-1:0] cur_y = '0;

  int cyc = 0;
  int beats = 0;
  int ps_cnt = 0;
  int done_cnt = 0;
  int last_hs = 0;
  int last_ps = 0;
  logic       prev_v = 1'b0;
  logic       prev_hs = 1'b0;
  logic [1:0] prev_m = 2'd0;
  logic       prev_err = 1'b0;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      issue_q.delete();
      out_q.delete();
      prev_v = 1'b0;
      prev_hs = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (prev_v && !prev_hs) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_mode", int'(out_mode), int'(prev_m));
      end
      if (pred_start) begin
        ps_cnt++;
        last_ps = cyc;
        if (issue_q.size() == 0) chk("issue_extra", 1, 0);
        else chk("issue_mode", int'(pred_mode), issue_q.pop_front());
      end
      if (out_valid && out_ready) begin
        beats++;
        last_hs = cyc;
        if (out_q.size() == 0) chk("beat_extra", 1, 0);
        else chk("out_mode", int'(out_mode), out_q.pop_front());
      end
      if (mb_busy) begin
        chk("pred_x", int'(pred_x), int'(cur_x));
        chk("pred_y", int'(pred_y), int'(cur_y));
      end
      if (mb_done) begin
        done_cnt++;
        chk("done_lat", cyc - last_hs, 2);
      end
      if (err_timeout && !prev_err) chk("to_lat", cyc - last_ps, TO);
      prev_v = out_valid;
      prev_hs = out_valid & out_ready;
      prev_m = out_mode;
      prev_err = err_timeout;
    end
  end

  // Predictor model: done pulse two cycles after start unless hung.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && pred_start && !(hang_en && pred_mode == hang_mode)) begin
        @(posedge clk);
        @(posedge clk);
        #1 pd_model = 1'b1;
        @(posedge clk);
        #1 pd_model = 1'b0;
      end
    end
  end

  // Downstream model: ready always, or 10 low cycles per beat when stalling.
  int wcnt = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pd_inj = inject_en & out_valid;
      if (!stall_en) begin
        out_ready = 1'b1;
        wcnt = 0;
      end else if (!out_valid) begin
        out_ready = 1'b0;
        wcnt = 0;
      end else if (wcnt < 10) begin
        out_ready = 1'b0;
        wcnt++;
      end else begin
        out_ready = 1'b1;
        wcnt = 0;
      end
    end
  end

  int b_beats, b_ps, b_done;

  task automatic start_mb(input logic [BN-1:0] x, input logic [BN-1:0] y);
    cur_x = x;
    cur_y = y;
    for (int m = 0; m < 4; m++) begin
      if (m < 2 || (m == 2 && y != 0) || (m == 3 && x != 0)) begin
        issue_q.push_back(m);
        if (!(hang_en && m == int'(hang_mode))) out_q.push_back(m);
      end
    end
    b_beats = beats;
    b_ps = ps_cnt;
    b_done = done_cnt;
    @(posedge clk);
    #1;
    mb_start = 1'b1;
    mb_x = x;
    mb_y = y;
    @(posedge clk);
    #1;
    mb_start = 1'b0;
    chk("busy_t1", int'(mb_busy), 1);
    chk("pstart_t1", int'(pred_start), 1);
    chk("err_clr", int'(err_timeout), 0);
  endtask

  task automatic wait_done(input int n_out, input int n_ps);
    int k = 0;
    while (done_cnt == b_done && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt", done_cnt - b_done, 1);
    chk("busy_idle", int'(mb_busy), 0);
    chk("beats", beats - b_beats, n_out);
    chk("starts", ps_cnt - b_ps, n_ps);
    chk("q_empty", out_q.size(), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    mb_start = 1'b0;
    mb_x = '0;
    mb_y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(mb_busy), 0);
    chk("rst_pstart", int'(pred_start), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_err", int'(err_timeout), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_done", int'(mb_done), 0);
    chk("idle_mode", int'(pred_mode), 0);

    // Inner macroblock: all four modes.
    start_mb(10'd3, 10'd2);
    wait_done(4, 4);
    chk("inner_err", int'(err_timeout), 0);

    // Top-left: DC and TM only.
    start_mb(10'd0, 10'd0);
    wait_done(2, 2);

    // Top row with a slow consumer: DC, TM, HE.
    stall_en = 1'b1;
    start_mb(10'd5, 10'd0);
    wait_done(3, 3);
    stall_en = 1'b0;

    // Predictor hangs on TM; late done must be ignored.
    hang_en = 1'b1;
    hang_mode = 2'd1;
    start_mb(10'd1, 10'd1);
    k = 0;
    while (!err_timeout && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("err_set", int'(err_timeout), 1);
    pd_late = 1'b1;
    @(posedge clk);
    #1;
    pd_late = 1'b0;
    wait_done(3, 4);
    chk("err_sticky", int'(err_timeout), 1);
    hang_en = 1'b0;

    // Stray mb_start while busy and pred_done during OUT.
    inject_en = 1'b1;
    start_mb(10'd3, 10'd2);
    repeat (3) @(posedge clk);
    #1;
    mb_start = 1'b1;
    mb_x = 10'd0;
    mb_y = 10'd0;
    @(posedge clk);
    #1;
    mb_start = 1'b0;
    wait_done(4, 4);
    inject_en = 1'b0;

    // Reset during WAIT of VE, then a clean full run.
    start_mb(10'd3, 10'd2);
    k = 0;
    while (!(pred_start && pred_mode == 2'd2) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("ve_issue", int'(pred_mode), 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(mb_busy), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_pstart", int'(pred_start), 0);
    chk("arst_mode", int'(pred_mode), 0);
    chk("arst_x", int'(pred_x), 0);
    chk("arst_y", int'(pred_y), 0);
    chk("arst_done", int'(mb_done), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arst_nodone", done_cnt - b_done, 0);
    start_mb(10'd3, 10'd2);
    wait_done(4, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
